// File: rtl/omok_pkg.sv
// Shared definitions for the Omok display path: board geometry, cell-index
// helpers and the scan FSM state encoding.
package omok_pkg;

    localparam int BOARD_N = 5;
    localparam int CELLS   = BOARD_N * BOARD_N;
    localparam int IDX_W   = 5;
    localparam int ROW_W   = 3;

    // Cursor indices at or above this value mean "no cursor on the board".
    localparam logic [IDX_W-1:0] NO_CURSOR = IDX_W'(CELLS);

    typedef enum logic {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } scan_state_t;

    function automatic logic [ROW_W-1:0] idx_row(input logic [IDX_W-1:0] idx);
        return ROW_W'(idx / IDX_W'(BOARD_N));
    endfunction

    function automatic logic [ROW_W-1:0] idx_col(input logic [IDX_W-1:0] idx);
        return ROW_W'(idx % IDX_W'(BOARD_N));
    endfunction

    function automatic logic [IDX_W-1:0] cell_idx(input logic [ROW_W-1:0] row,
                                                  input logic [ROW_W-1:0] col);
        return IDX_W'(row * IDX_W'(BOARD_N) + IDX_W'(col));
    endfunction

endpackage

// File: rtl/omok_scan_timer.sv
// Row-scan sequencer for the LED matrix: blank/dwell slot counter, row counter
// and the BLANK/DRIVE FSM, plus the frame and snapshot strobes.
//
// state   | meaning
// S_BLANK | all row and column drivers off for BLANK_CYCLES cycles
// S_DRIVE | current row driven for DWELL_CYCLES cycles, then row advances
module omok_scan_timer
    import omok_pkg::*;
#(
    parameter int DWELL_CYCLES = 8,
    parameter int BLANK_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic [ROW_W-1:0] o_row,
    output logic             o_drive,
    output logic             o_frame_start,
    output logic             o_frame_wrap,
    output logic             o_snap_load
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(BOARD_N - 1);

    scan_state_t      r_state;
    scan_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [ROW_W-1:0] r_row;
    logic [ROW_W-1:0] w_row_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_BLANK;
            r_cnt   <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_row   <= w_row_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_row_nxt   = r_row;
        case (r_state)
            S_BLANK: begin
                if (r_cnt == BLANK_LAST) begin
                    w_state_nxt = S_DRIVE;
                    w_cnt_nxt   = '0;
                end
            end
            S_DRIVE: begin
                if (r_cnt == DWELL_LAST) begin
                    w_state_nxt = S_BLANK;
                    w_cnt_nxt   = '0;
                    w_row_nxt   = (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_BLANK;
                w_cnt_nxt   = '0;
                w_row_nxt   = '0;
            end
        endcase
    end

    // Strobes describe the current timer state; the top registers the pins
    // from them, so the pins trail the timer by exactly one cycle.
    assign o_row         = r_row;
    assign o_drive       = (r_state == S_DRIVE);
    assign o_frame_start = (r_state == S_DRIVE) && (r_row == '0) && (r_cnt == '0);
    assign o_frame_wrap  = (r_state == S_DRIVE) && (r_row == LAST_ROW) && (r_cnt == DWELL_LAST);
    assign o_snap_load   = (r_state == S_BLANK) && (r_row == '0) && (r_cnt == BLANK_LAST);

endmodule

// File: rtl/omok_led_scan.sv
// Multiplexed 5x5 bi-colour LED driver for the Omok board: per-frame snapshot,
// cursor blink and column decode. Blinking is built only with OMOK_SCAN_CURSOR_BLINK_EN.
module omok_led_scan
    import omok_pkg::*;
#(
    parameter int DWELL_CYCLES = 8,
    parameter int BLANK_CYCLES = 2,
    parameter int BLINK_FRAMES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CELLS-1:0]   board_occ,
    input  logic [CELLS-1:0]   board_white,
    input  logic [IDX_W-1:0]   cursor_idx,
    output logic [BOARD_N-1:0] row_n,
    output logic [BOARD_N-1:0] col_red,
    output logic [BOARD_N-1:0] col_grn,
    output logic               frame_start
);

    logic [ROW_W-1:0]   w_row;
    logic               w_drive;
    logic               w_frame_start;
    logic               w_frame_wrap;
    logic               w_snap_load;
    logic               w_blink_on;

    logic [CELLS-1:0]   r_snap_occ;
    logic [CELLS-1:0]   r_snap_white;
    logic [IDX_W-1:0]   r_snap_cur;

    logic               w_cur_valid;
    logic [ROW_W-1:0]   w_cur_row;
    logic [ROW_W-1:0]   w_cur_col;
    logic [IDX_W-1:0]   w_cell;
    logic [BOARD_N-1:0] w_red_nxt;
    logic [BOARD_N-1:0] w_grn_nxt;

    omok_scan_timer #(
        .DWELL_CYCLES (DWELL_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk           (clk),
        .rst           (rst),
        .o_row         (w_row),
        .o_drive       (w_drive),
        .o_frame_start (w_frame_start),
        .o_frame_wrap  (w_frame_wrap),
        .o_snap_load   (w_snap_load)
    );

    // Captured once per frame, one cycle before row 0 lights, so a whole
    // frame is always drawn from one consistent board.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_snap_occ   <= '0;
            r_snap_white <= '0;
            r_snap_cur   <= '0;
        end else if (w_snap_load) begin
            r_snap_occ   <= board_occ;
            r_snap_white <= board_white;
            r_snap_cur   <= cursor_idx;
        end
    end

`ifdef OMOK_SCAN_CURSOR_BLINK_EN
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [FRM_W-1:0] r_frm_cnt;
    logic             r_blink_on;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frm_cnt  <= '0;
            r_blink_on <= 1'b1;
        end else if (w_frame_wrap) begin
            if (r_frm_cnt == FRM_LAST) begin
                r_frm_cnt  <= '0;
                r_blink_on <= ~r_blink_on;
            end else begin
                r_frm_cnt  <= r_frm_cnt + 1'b1;
            end
        end
    end

    assign w_blink_on = r_blink_on;
`else
    logic w_unused;

    assign w_unused   = ^{w_frame_wrap, BLINK_FRAMES[0]};
    assign w_blink_on = 1'b1;
`endif

    always_comb begin
        w_red_nxt   = '0;
        w_grn_nxt   = '0;
        w_cell      = '0;
        w_cur_valid = (r_snap_cur < NO_CURSOR);
        w_cur_row   = idx_row(r_snap_cur);
        w_cur_col   = idx_col(r_snap_cur);
        for (int c = 0; c < BOARD_N; c++) begin
            w_cell = cell_idx(w_row, ROW_W'(c));
            if (w_cur_valid && w_blink_on && (w_cur_row == w_row) && (w_cur_col == ROW_W'(c))) begin
                w_red_nxt[c] = 1'b1;
                w_grn_nxt[c] = 1'b1;
            end else if (r_snap_occ[w_cell]) begin
                w_red_nxt[c] = ~r_snap_white[w_cell];
                w_grn_nxt[c] =  r_snap_white[w_cell];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_n       <= '1;
            col_red     <= '0;
            col_grn     <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= w_frame_start;
            if (w_drive) begin
                row_n   <= ~(BOARD_N'(1) << w_row);
                col_red <= w_red_nxt;
                col_grn <= w_grn_nxt;
            end else begin
                row_n   <= '1;
                col_red <= '0;
                col_grn <= '0;
            end
        end
    end

endmodule
